flt2int: RTL
============

Name: flt2int

Overview:
- Float-to-integer conversion stage, directly downstream of the integer-to-float stage.
- Consumes the 16-bit half-precision value that stage leaves in data memory and converts it to a 16-bit sign-magnitude integer, rounding to nearest-even.
- Writes the result back to data memory.
- Runs as a multi-cycle FSM on the shared byte-wide data-memory port with a req/done handshake, like its sibling conversion stages.

Parameters:
- SRC_ADDR, 8'd2: address of the float high byte; the low byte is at SRC_ADDR+1.
- DST_ADDR, 8'd6: address of the integer high byte; the low byte is at DST_ADDR+1.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  start pulse, sampled only in IDLE.
- done  output  1  high once the result is written; held until the next accepted req.
- mem_addr  output  8  data-memory byte address.
- mem_rd  output  1  read strobe.
- mem_wr  output  1  write strobe; memory writes mem_wdata at the clk edge.
- mem_wdata  output  8  write data.
- mem_rdata  input  8  combinational read data for mem_addr; sampled at the clk edge.

Behaviour:
Formats:
- Float input: bit15 sign, [14:10] exponent e (bias 15), [9:0] mantissa m, hidden 1. Value = (1.m)*2^(e-15). Stored big-endian.
- Integer output: bit15 sign, [14:0] magnitude. Stored big-endian.

Reset and strobes:
- Reset (reset=0, async) forces IDLE and clears done, mem_rd, mem_wr, mem_addr, mem_wdata and all datapath registers to 0.
- Reset asserted mid-operation aborts the operation; no further memory write occurs.
- Memory strobes are decoded from state (Moore).

FSM:
- IDLE: req=1 clears done and moves to RD_HI. req=0 stays in IDLE, done unchanged.
- RD_HI: addr=SRC_ADDR, rd=1; capture high byte.
- RD_LO: addr=SRC_ADDR+1, rd=1; capture low byte.
- CLASSIFY, by exponent e:
  - e=0 (zero or denormal), or e<=13: result magnitude 0; go to ROUND with n=0.
  - e>=30 (includes inf and NaN): magnitude saturates to 7FFF; go to ROUND with n=0.
  - 14<=e<=29: load the 11-bit significand {1,m} and set n=|e-25|; go to SHIFT, or to ROUND if n=0.
- SHIFT: one bit per cycle, n cycles.
  - e>25: shift left, zero fill.
  - e<25: shift right through a guard bit, OR-ing every shifted-out bit beyond guard into sticky.
  - Max n=11 (e=14).
- ROUND (round-to-nearest-even):
  - Increment if guard & (sticky | lsb).
  - No overflow is possible in the normal range (max magnitude 0x7FF0 at e=29).
- Zero rule: if the final magnitude is 0, the sign is forced to 0; negative zero is never written.
- WR_HI: addr=DST_ADDR, wr=1, wdata=result[15:8].
- WR_LO: addr=DST_ADDR+1, wr=1, wdata=result[7:0].
- DONE: done=1; return to IDLE the following cycle. done stays 1 in IDLE until the next req.

Timing and handshake:
- Latency: done rises on the (6+n)th rising edge after the edge that sampled req. Range 6 to 17 cycles.
- req outside IDLE/DONE is ignored, with no restart and no corruption.
- req held high continuously restarts the conversion each time the FSM reaches IDLE.
- Only SRC and DST byte addresses are touched; mem_rd and mem_wr are never asserted together.

Test Plan:
- Basic positive: mem[2:3]=0x4D00 (20.0), pulse req -> mem[6:7]=0x0014; done rises 12 cycles after the req edge (n=6).
- Negative and exact left shift:
  - 0xC500 (-5.0) -> 0x8005.
  - 0x77FF (e=29, n=4) -> 0x7FF0; latency 10.
- Ties to even:
  - 0x3800 (0.5) -> 0x0000.
  - 0x3E00 (1.5) -> 0x0002.
  - 0x4100 (2.5) -> 0x0002.
  - 0x3C01 (slightly above 1.0) -> 0x0001.
- Specials:
  - 0x8000 (-0) -> 0x0000.
  - 0x0001 (denormal) -> 0x0000.
  - 0x7800 (32768) -> 0x7FFF.
  - 0xFC00 (-inf) -> 0xFFFF.
  - 0x7E00 (NaN) -> 0x7FFF.
  - Each with latency 6.
- Reset and busy req:
  - Drop reset during SHIFT of 0x4D00 -> done=0 and strobes low immediately; mem[6:7] unchanged.
  - A fresh req after reset release yields 0x0014.
  - req pulsed during SHIFT -> ignored; single write pair; done once.
- Back-to-back: hold req high for two conversions with mem[2:3] changed between them -> each result is correct and done drops on each accepted req.

Source files
------------

// File: rtl/flt2int.sv
// Half-precision float to 16-bit sign-magnitude integer converter.
// Reads the float from data memory, rounds to nearest-even and writes the integer back.
module flt2int #(
    parameter logic [7:0] SRC_ADDR = 8'd2,
    parameter logic [7:0] DST_ADDR = 8'd6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    output logic       done,
    output logic [7:0] mem_addr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic [3:0] dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_RD_HI    = 4'd1,
        S_RD_LO    = 4'd2,
        S_CLASSIFY = 4'd3,
        S_SHIFT    = 4'd4,
        S_ROUND    = 4'd5,
        S_WR_HI    = 4'd6,
        S_WR_LO    = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_float;
    logic [14:0] r_mag;
    logic        r_guard;
    logic        r_sticky;
    logic        r_left;
    logic [4:0]  r_n;
    logic [15:0] r_result;
    logic        r_done;

    logic [4:0]  w_exp;
    logic [4:0]  w_shamt;
    logic        w_normal;
    logic        w_inc;
    logic [14:0] w_mag_rnd;
    logic        w_sign_out;

    assign w_exp      = r_float[14:10];
    assign w_shamt    = (w_exp > 5'd25) ? (w_exp - 5'd25) : (5'd25 - w_exp);
    assign w_normal   = (w_exp >= 5'd14) && (w_exp <= 5'd29);
    assign w_inc      = r_guard & (r_sticky | r_mag[0]);
    assign w_mag_rnd  = r_mag + {14'd0, w_inc};
    assign w_sign_out = r_float[15] & (|w_mag_rnd);

    assign done      = r_done;
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = req ? S_RD_HI : S_IDLE;
            S_RD_HI:    w_next = S_RD_LO;
            S_RD_LO:    w_next = S_CLASSIFY;
            S_CLASSIFY: w_next = (w_normal && (w_shamt != 5'd0)) ? S_SHIFT : S_ROUND;
            S_SHIFT:    w_next = (r_n == 5'd1) ? S_ROUND : S_SHIFT;
            S_ROUND:    w_next = S_WR_HI;
            S_WR_HI:    w_next = S_WR_LO;
            S_WR_LO:    w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = 8'd0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = 8'd0;
        case (r_state)
            S_RD_HI: begin
                mem_addr = SRC_ADDR;
                mem_rd   = 1'b1;
            end
            S_RD_LO: begin
                mem_addr = SRC_ADDR + 8'd1;
                mem_rd   = 1'b1;
            end
            S_WR_HI: begin
                mem_addr  = DST_ADDR;
                mem_wr    = 1'b1;
                mem_wdata = r_result[15:8];
            end
            S_WR_LO: begin
                mem_addr  = DST_ADDR + 8'd1;
                mem_wr    = 1'b1;
                mem_wdata = r_result[7:0];
            end
            default: ;
        endcase
    end

    // Right shifts keep one guard bit; everything shifted past it folds into sticky.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_float  <= 16'd0;
            r_mag    <= 15'd0;
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_left   <= 1'b0;
            r_n      <= 5'd0;
            r_result <= 16'd0;
            r_done   <= 1'b0;
        end else begin
            if (r_state == S_WR_LO) begin
                r_done <= 1'b1;
            end else if ((r_state == S_IDLE) && req) begin
                r_done <= 1'b0;
            end
            case (r_state)
                S_RD_HI: r_float[15:8] <= mem_rdata;
                S_RD_LO: r_float[7:0]  <= mem_rdata;
                S_CLASSIFY: begin
                    r_guard  <= 1'b0;
                    r_sticky <= 1'b0;
                    r_left   <= 1'b0;
                    r_n      <= 5'd0;
                    if (w_exp <= 5'd13) begin
                        r_mag <= 15'd0;
                    end else if (w_exp >= 5'd30) begin
                        r_mag <= 15'h7FFF;
                    end else begin
                        r_mag  <= {4'd0, 1'b1, r_float[9:0]};
                        r_left <= (w_exp > 5'd25);
                        r_n    <= w_shamt;
                    end
                end
                S_SHIFT: begin
                    if (r_left) begin
                        r_mag <= {r_mag[13:0], 1'b0};
                    end else begin
                        r_mag    <= {1'b0, r_mag[14:1]};
                        r_guard  <= r_mag[0];
                        r_sticky <= r_sticky | r_guard;
                    end
                    r_n <= r_n - 5'd1;
                end
                S_ROUND: r_result <= {w_sign_out, w_mag_rnd};
                default: ;
            endcase
        end
    end

endmodule
